// File: rtl/cpu16_ctrl_pkg.sv
// Shared encodings for the 16-bit CPU control sequencer: opcode classes, FSM states,
// fault codes and the control-field bundle carried from decode to execute.
package cpu16_ctrl_pkg;

  localparam logic [3:0] OP_IMM  = 4'b0000;
  localparam logic [3:0] OP_BR   = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_PUSH = 4'b0100;
  localparam logic [3:0] OP_POP  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  // Any opcode with bit 3 set is an ALU op; bit 2 picks the ALU function.
  localparam logic       OP_ALU  = 1'b1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ISSUE    = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  localparam logic [2:0] FAULT_NONE      = 3'd0;
  localparam logic [2:0] FAULT_ILLEGAL   = 3'd1;
  localparam logic [2:0] FAULT_OVERFLOW  = 3'd2;
  localparam logic [2:0] FAULT_UNDERFLOW = 3'd3;
  localparam logic [2:0] FAULT_TIMEOUT   = 3'd4;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_LO   = 2'b01;
  localparam logic [1:0] FIELD_HI   = 2'b11;

  typedef struct packed {
    logic       imm_s;
    logic       branch;
    logic [1:0] alu_s;
    logic [1:0] mem_s;
    logic [1:0] stack_s;
    logic [1:0] shift_s;
  } ctrl_fields_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: maps an opcode onto control fields and flags illegal,
// memory and stack operations. Opcodes wider than 4 bits must have zero upper bits.
module opcode_classify
  import cpu16_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  output ctrl_fields_t   o_fields,
  output logic           o_illegal,
  output logic           o_is_mem,
  output logic           o_is_stack
);

  logic [3:0] w_op;
  logic       w_hi_set;

  assign w_op = i_opcode[3:0];

  generate
    if (OPW > 4) begin : g_wide
      assign w_hi_set = |i_opcode[OPW-1:4];
    end else begin : g_narrow
      assign w_hi_set = 1'b0;
    end
  endgenerate

  always_comb begin
    o_fields   = '0;
    o_is_mem   = 1'b0;
    o_is_stack = 1'b0;
    if (w_op[3] == OP_ALU) begin
      o_fields.alu_s = {w_op[2], 1'b1};
    end else begin
      case (w_op)
        OP_IMM:  o_fields.imm_s  = 1'b1;
        OP_BR:   o_fields.branch = 1'b1;
        OP_LD:   begin o_fields.mem_s   = FIELD_LO; o_is_mem   = 1'b1; end
        OP_ST:   begin o_fields.mem_s   = FIELD_HI; o_is_mem   = 1'b1; end
        OP_PUSH: begin o_fields.stack_s = FIELD_LO; o_is_stack = 1'b1; end
        OP_POP:  begin o_fields.stack_s = FIELD_HI; o_is_stack = 1'b1; end
        OP_SHL:  o_fields.shift_s = FIELD_LO;
        OP_SHR:  o_fields.shift_s = FIELD_HI;
        default: o_fields = '0;
      endcase
    end
    // Illegal opcodes carry no control meaning at all.
    if (w_hi_set) begin
      o_fields   = '0;
      o_is_mem   = 1'b0;
      o_is_stack = 1'b0;
    end
  end

  assign o_illegal = w_hi_set;

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered control sequencer: accepts one opcode at a time, waits for memory/stack acks,
// presents the control word to execute, tracks stack depth and holds sticky faults.
module ctrl_sequencer
  import cpu16_ctrl_pkg::*;
#(
  parameter int unsigned OPW         = 4,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned TIMEOUT     = 64,
  localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_instr_valid,
  output logic           o_instr_ready,
  input  logic [OPW-1:0] i_opcode,
  output logic           o_ctrl_valid,
  input  logic           i_ctrl_ready,
  output logic           o_imm_s,
  output logic           o_branch,
  output logic [1:0]     o_alu_s,
  output logic [1:0]     o_mem_s,
  output logic [1:0]     o_stack_s,
  output logic [1:0]     o_shift_s,
  output logic           o_mem_req,
  input  logic           i_mem_ack,
  output logic [DW-1:0]  o_stack_depth,
  output logic           o_fault,
  output logic [2:0]     o_fault_code,
  input  logic           i_fault_clr
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    r_state,      w_state_nxt;
  ctrl_fields_t  r_fields,     w_fields_nxt;
  logic [DW-1:0] r_depth,      w_depth_nxt;
  logic [2:0]    r_fault_code, w_code_nxt;
  logic [CW-1:0] r_cnt,        w_cnt_nxt;

  ctrl_fields_t  w_dec;
  logic          w_illegal;
  logic          w_is_mem;
  logic          w_is_stack;

  opcode_classify #(
    .OPW (OPW)
  ) u_classify (
    .i_opcode   (i_opcode),
    .o_fields   (w_dec),
    .o_illegal  (w_illegal),
    .o_is_mem   (w_is_mem),
    .o_is_stack (w_is_stack)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_fields_nxt = r_fields;
    w_depth_nxt  = r_depth;
    w_code_nxt   = r_fault_code;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (i_instr_valid) begin
          w_fields_nxt = w_dec;
          if (w_illegal) begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FAULT_ILLEGAL;
          end else if (w_dec.stack_s == FIELD_LO && r_depth == DW'(STACK_DEPTH)) begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FAULT_OVERFLOW;
          end else if (w_dec.stack_s == FIELD_HI && r_depth == '0) begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FAULT_UNDERFLOW;
          end else if (w_is_mem || w_is_stack) begin
            w_state_nxt = ST_MEM_WAIT;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_MEM_WAIT: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // An ack in the final counted cycle still beats the timeout.
        if (i_mem_ack) begin
          w_state_nxt = ST_ISSUE;
        end else if (TIMEOUT > 0 && (32'(r_cnt) + 32'd1) == TIMEOUT) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FAULT_TIMEOUT;
        end
      end
      ST_ISSUE: begin
        if (i_ctrl_ready) begin
          w_state_nxt = ST_IDLE;
          if (r_fields.stack_s == FIELD_LO) begin
            w_depth_nxt = r_depth + DW'(1);
          end else if (r_fields.stack_s == FIELD_HI) begin
            w_depth_nxt = r_depth - DW'(1);
          end
        end
      end
      ST_FAULT: begin
        if (i_fault_clr) begin
          w_state_nxt  = ST_IDLE;
          w_code_nxt   = FAULT_NONE;
          w_fields_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_fields     <= '0;
      r_depth      <= '0;
      r_fault_code <= FAULT_NONE;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fields     <= w_fields_nxt;
      r_depth      <= w_depth_nxt;
      r_fault_code <= w_code_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign o_instr_ready = (r_state == ST_IDLE);
  assign o_ctrl_valid  = (r_state == ST_ISSUE);
  assign o_mem_req     = (r_state == ST_MEM_WAIT);
  assign o_fault       = (r_state == ST_FAULT);
  assign o_fault_code  = r_fault_code;
  assign o_stack_depth = r_depth;
  assign o_imm_s       = r_fields.imm_s;
  assign o_branch      = r_fields.branch;
  assign o_alu_s       = r_fields.alu_s;
  assign o_mem_s       = r_fields.mem_s;
  assign o_stack_s     = r_fields.stack_s;
  assign o_shift_s     = r_fields.shift_s;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios then random opcodes, each checked against a
// transaction-level model of the opcode map, stack depth and fault rules.
module tb_ctrl_sequencer;

  localparam int unsigned OPW = 6;
  localparam int unsigned SD  = 16;
  localparam int unsigned TO  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] opcode;
  logic           ctrl_valid;
  logic           ctrl_ready;
  logic           imm_s;
  logic           branch;
  logic [1:0]     alu_s;
  logic [1:0]     mem_s;
  logic [1:0]     stack_s;
  logic [1:0]     shift_s;
  logic           mem_req;
  logic           mem_ack;
  logic [4:0]     stack_depth;
  logic           fault;
  logic [2:0]     fault_code;
  logic           fault_clr;
  logic [9:0]     obs_fields;

  int n_cmp = 0;
  int n_err = 0;
  int m_depth = 0;

  always #5 clk = ~clk;

  assign obs_fields = {imm_s, branch, alu_s, mem_s, stack_s, shift_s};

  ctrl_sequencer #(
    .OPW         (OPW),
    .STACK_DEPTH (SD),
    .TIMEOUT     (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_instr_valid (instr_valid),
    .o_instr_ready (instr_ready),
    .i_opcode      (opcode),
    .o_ctrl_valid  (ctrl_valid),
    .i_ctrl_ready  (ctrl_ready),
    .o_imm_s       (imm_s),
    .o_branch      (branch),
    .o_alu_s       (alu_s),
    .o_mem_s       (mem_s),
    .o_stack_s     (stack_s),
    .o_shift_s     (shift_s),
    .o_mem_req     (mem_req),
    .i_mem_ack     (mem_ack),
    .o_stack_depth (stack_depth),
    .o_fault       (fault),
    .o_fault_code  (fault_code),
    .i_fault_clr   (fault_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected control word {imm, branch, alu, mem, stack, shift} straight from the opcode map.
  function automatic logic [9:0] exp_fields(input logic [5:0] op);
    int v;
    logic [1:0] alu, mem, stk, sh;
    if (op[5:4] != 2'b00) return 10'd0;
    v   = int'(op[3:0]);
    alu = (v >= 8) ? (((v % 8) >= 4) ? 2'b11 : 2'b01) : 2'b00;
    mem = (v == 2) ? 2'b01 : (v == 3) ? 2'b11 : 2'b00;
    stk = (v == 4) ? 2'b01 : (v == 5) ? 2'b11 : 2'b00;
    sh  = (v == 6) ? 2'b01 : (v == 7) ? 2'b11 : 2'b00;
    return {(v == 0), (v == 1), alu, mem, stk, sh};
  endfunction

  task automatic clear_fault(input int code);
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_code", 32'(fault_code), 32'(code));
    chk("fault_mem_req", 32'(mem_req), 32'd0);
    chk("fault_instr_ready", 32'(instr_ready), 32'd0);
    chk("fault_ctrl_valid", 32'(ctrl_valid), 32'd0);
    tick;
    chk("fault_sticky", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    tick;
    fault_clr = 1'b0;
    chk("clr_instr_ready", 32'(instr_ready), 32'd1);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code", 32'(fault_code), 32'd0);
    chk("clr_fields", 32'(obs_fields), 32'd0);
    chk("clr_depth", 32'(stack_depth), 32'(m_depth));
  endtask

  // ack_dly: mem_req cycle in which mem_ack is driven (> TO means never); rdy_dly: ISSUE stall.
  task automatic run_op(input logic [5:0] op, input int ack_dly, input int rdy_dly);
    int v;
    int code;
    bit legal, memop;
    logic [9:0] ef;
    v     = int'(op[3:0]);
    legal = (op[5:4] == 2'b00);
    ef    = exp_fields(op);
    memop = legal && v >= 2 && v <= 5;
    code  = !legal ? 1 : (v == 4 && m_depth == SD) ? 2 : (v == 5 && m_depth == 0) ? 3 : 0;
    chk("idle_instr_ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    opcode      = op;
    tick;
    instr_valid = 1'b0;
    if (code != 0) begin
      clear_fault(code);
      return;
    end
    if (memop) begin
      for (int i = 1; i <= TO; i++) begin
        chk("wait_mem_req", 32'(mem_req), 32'd1);
        chk("wait_ctrl_valid", 32'(ctrl_valid), 32'd0);
        chk("wait_fields", 32'(obs_fields), 32'(ef));
        if (i == ack_dly) mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        if (i == ack_dly) break;
      end
      if (ack_dly > TO) begin
        clear_fault(4);
        return;
      end
    end
    for (int j = 0; j <= rdy_dly; j++) begin
      chk("issue_ctrl_valid", 32'(ctrl_valid), 32'd1);
      chk("issue_mem_req", 32'(mem_req), 32'd0);
      chk("issue_fields", 32'(obs_fields), 32'(ef));
      if (j == rdy_dly) ctrl_ready = 1'b1;
      tick;
      ctrl_ready = 1'b0;
    end
    if (legal && v == 4) m_depth++;
    else if (legal && v == 5) m_depth--;
    chk("done_ctrl_valid", 32'(ctrl_valid), 32'd0);
    chk("done_instr_ready", 32'(instr_ready), 32'd1);
    chk("done_depth", 32'(stack_depth), 32'(m_depth));
  endtask

  initial begin
    logic [5:0] op;
    rst         = 1'b1;
    instr_valid = 1'b0;
    opcode      = '0;
    ctrl_ready  = 1'b0;
    mem_ack     = 1'b0;
    fault_clr   = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_code", 32'(fault_code), 32'd0);
    chk("rst_depth", 32'(stack_depth), 32'd0);
    chk("rst_fields", 32'(obs_fields), 32'd0);

    run_op(6'b001010, 1, 0);   // ALU, single-cycle issue
    run_op(6'b000011, 3, 0);   // store, ack in third mem_req cycle
    run_op(6'b000101, 1, 0);   // pop on empty stack
    run_op(6'b010000, 1, 0);   // upper opcode bits set
    run_op(6'b000010, 99, 0);  // load never acked
    run_op(6'b001111, 1, 5);   // ISSUE stalled by execute
    run_op(6'b000010, TO, 0);  // ack in the timeout cycle wins
    for (int k = 0; k < SD; k++) run_op(6'b000100, 1, 0);
    run_op(6'b000100, 1, 0);   // push on full stack

    // Reset in the middle of MEM_WAIT throws away everything, including depth.
    instr_valid = 1'b1;
    opcode      = 6'b000010;
    tick;
    instr_valid = 1'b0;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick;
    rst     = 1'b0;
    m_depth = 0;
    chk("midrst_instr_ready", 32'(instr_ready), 32'd1);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_depth", 32'(stack_depth), 32'd0);

    // Stray handshakes in IDLE must be ignored.
    mem_ack    = 1'b1;
    fault_clr  = 1'b1;
    ctrl_ready = 1'b1;
    tick;
    mem_ack    = 1'b0;
    fault_clr  = 1'b0;
    ctrl_ready = 1'b0;
    chk("stray_instr_ready", 32'(instr_ready), 32'd1);
    chk("stray_ctrl_valid", 32'(ctrl_valid), 32'd0);
    chk("stray_mem_req", 32'(mem_req), 32'd0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(16, 63));
      else op = {2'b00, 4'($urandom_range(0, 15))};
      run_op(op, int'($urandom_range(1, 5)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
